master_req_tracker: RTL and testbench

Per-master request tracker for the two-master / two-slave bus. It latches a master transaction, chooses the target slave from the address MSB, and drives the `sfor` / `req_stat` pair consumed by each slave's round-robin ack arbiter. It collects that arbiter's ack and the slave's read response and returns `master_ack`, `master_resp` and `master_rdata` to the master. One instance is built per master, directly upstream of the arbiters.

---
 rtl/bus_pkg.sv | 16 +
 rtl/req_timeout_cnt.sv | 39 +++
 rtl/master_req_tracker.sv | 151 +++++++++++++++
 tb/tb_master_req_tracker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master / two-slave bus: request state codes
// (also decoded by the slave ack arbiters) and default bus widths.
package bus_pkg;

    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;
    localparam int TO_CNT_W  = 8;

    typedef enum logic [1:0] {
        NO_REQ = 2'd0,
        WAIT   = 2'd1,
        W_ACK  = 2'd2,
        W_DATA = 2'd3
    } req_state_e;

endpackage

// File: rtl/req_timeout_cnt.sv
// Saturating wait-cycle counter; expired is high while the count equals TIMEOUT.
module req_timeout_cnt
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_CNT_W-1:0] LIMIT   = TO_CNT_W'(TIMEOUT);
    localparam logic [TO_CNT_W-1:0] CNT_MAX = '1;

    logic [TO_CNT_W-1:0] cnt_q;
    logic [TO_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/master_req_tracker.sv
// Per-master request tracker: latches a master transaction, presents it to the
// selected slave's arbiter and returns ack / read response / timeout error.
module master_req_tracker
    import bus_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          master_req,
    input  logic          master_cmd,
    input  logic [AW-1:0] master_addr,
    input  logic [DW-1:0] master_wdata,
    output logic          master_ack,
    output logic          master_resp,
    output logic [DW-1:0] master_rdata,
    output logic          master_err,
    input  logic [1:0]    slave_busy,
    input  logic          ack_in,
    input  logic          resp_in,
    input  logic [DW-1:0] rdata_in,
    output logic          sfor,
    output logic [1:0]    req_stat,
    output logic [AW-1:0] slave_addr,
    output logic          slave_cmd,
    output logic [DW-1:0] slave_wdata
);

    req_state_e    state_q, state_d;
    logic          ack_q, ack_d;
    logic          resp_q, resp_d;
    logic          err_q, err_d;
    logic          sfor_q, sfor_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          cmd_q, cmd_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          latch_req;
    logic          capture_rdata;
    logic          cnt_clr;
    logic          cnt_en;
    logic          expired;

    req_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    // An exit event is checked before the timeout so a late ack/resp still wins.
    always_comb begin
        state_d       = state_q;
        ack_d         = 1'b0;
        resp_d        = 1'b0;
        err_d         = 1'b0;
        latch_req     = 1'b0;
        capture_rdata = 1'b0;
        case (state_q)
            NO_REQ: begin
                if (master_req) begin
                    latch_req = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!slave_busy[sfor_q]) begin
                    state_d = W_ACK;
                end
            end
            W_ACK: begin
                if (ack_in) begin
                    ack_d   = 1'b1;
                    state_d = cmd_q ? NO_REQ : W_DATA;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = NO_REQ;
                end
            end
            W_DATA: begin
                if (resp_in) begin
                    resp_d        = 1'b1;
                    capture_rdata = 1'b1;
                    state_d       = NO_REQ;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = NO_REQ;
                end
            end
            default: state_d = NO_REQ;
        endcase
    end

    assign cnt_clr = (state_d != state_q);
    assign cnt_en  = (state_q == W_ACK) || (state_q == W_DATA);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= NO_REQ;
            ack_q   <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    // Request fields only load in NO_REQ, so they stay stable for the whole transaction.
    always_comb begin
        sfor_d  = latch_req ? master_addr[AW-1] : sfor_q;
        addr_d  = latch_req ? master_addr : addr_q;
        cmd_d   = latch_req ? master_cmd : cmd_q;
        wdata_d = latch_req ? master_wdata : wdata_q;
        rdata_d = capture_rdata ? rdata_in : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sfor_q  <= 1'b0;
            addr_q  <= '0;
            cmd_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            sfor_q  <= sfor_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign master_ack   = ack_q;
    assign master_resp  = resp_q;
    assign master_err   = err_q;
    assign master_rdata = rdata_q;
    assign sfor         = sfor_q;
    assign req_stat     = state_q;
    assign slave_addr   = addr_q;
    assign slave_cmd    = cmd_q;
    assign slave_wdata  = wdata_q;

endmodule

// File: tb/tb_master_req_tracker.sv
// Directed vector bench for master_req_tracker (TIMEOUT=4): a cycle table for
// write/read/back-to-back traffic plus sequences for busy, timeout and reset.
module tb_master_req_tracker;

    typedef struct {
        logic        rst_n;
        logic        req;
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  busy;
        logic        ack;
        logic        resp;
        logic [31:0] rdata;
        logic [1:0]  e_stat;
        logic        e_ack;
        logic        e_resp;
        logic        e_err;
        logic        e_sfor;
        logic [31:0] e_saddr;
        logic        e_scmd;
        logic [31:0] e_swdata;
        logic [31:0] e_rdata;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        master_req;
    logic        master_cmd;
    logic [31:0] master_addr;
    logic [31:0] master_wdata;
    logic        master_ack;
    logic        master_resp;
    logic [31:0] master_rdata;
    logic        master_err;
    logic [1:0]  slave_busy;
    logic        ack_in;
    logic        resp_in;
    logic [31:0] rdata_in;
    logic        sfor;
    logic [1:0]  req_stat;
    logic [31:0] slave_addr;
    logic        slave_cmd;
    logic [31:0] slave_wdata;

    int total = 0;
    int bad   = 0;
    int step_no = 0;

    master_req_tracker #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .master_req   (master_req),
        .master_cmd   (master_cmd),
        .master_addr  (master_addr),
        .master_wdata (master_wdata),
        .master_ack   (master_ack),
        .master_resp  (master_resp),
        .master_rdata (master_rdata),
        .master_err   (master_err),
        .slave_busy   (slave_busy),
        .ack_in       (ack_in),
        .resp_in      (resp_in),
        .rdata_in     (rdata_in),
        .sfor         (sfor),
        .req_stat     (req_stat),
        .slave_addr   (slave_addr),
        .slave_cmd    (slave_cmd),
        .slave_wdata  (slave_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input vec_t v);
        rst_n        = v.rst_n;
        master_req   = v.req;
        master_cmd   = v.cmd;
        master_addr  = v.addr;
        master_wdata = v.wdata;
        slave_busy   = v.busy;
        ack_in       = v.ack;
        resp_in      = v.resp;
        rdata_in     = v.rdata;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at step %0d: got %h, expected %h", name, step_no, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v);
        chk("req_stat",     32'(req_stat),     32'(v.e_stat));
        chk("master_ack",   32'(master_ack),   32'(v.e_ack));
        chk("master_resp",  32'(master_resp),  32'(v.e_resp));
        chk("master_err",   32'(master_err),   32'(v.e_err));
        chk("sfor",         32'(sfor),         32'(v.e_sfor));
        chk("slave_addr",   slave_addr,        v.e_saddr);
        chk("slave_cmd",    32'(slave_cmd),    32'(v.e_scmd));
        chk("slave_wdata",  slave_wdata,       v.e_swdata);
        chk("master_rdata", master_rdata,      v.e_rdata);
    endtask

    task automatic step(input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(v);
        step_no++;
    endtask

    // Keep latched-field expectations, drop all inputs and expected pulses.
    function automatic vec_t idle(input vec_t p);
        vec_t v;
        v        = p;
        v.rst_n  = 1'b1;
        v.req    = 1'b0;
        v.cmd    = 1'b0;
        v.addr   = '0;
        v.wdata  = '0;
        v.busy   = 2'b00;
        v.ack    = 1'b0;
        v.resp   = 1'b0;
        v.rdata  = '0;
        v.e_ack  = 1'b0;
        v.e_resp = 1'b0;
        v.e_err  = 1'b0;
        return v;
    endfunction

    vec_t tbl [16];
    vec_t v;

    initial begin
        //             rst req cmd addr          wdata         busy ack resp rdata        | stat ack resp err sfor saddr         scmd swdata        rdata
        tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b0,1'b0,32'h0,        2'd0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0};
        tbl[1]  = '{1'b1,1'b1,1'b1,32'h8000_0010,32'h1234_5678,2'b00,1'b0,1'b0,32'h0,        2'd1,1'b0,1'b0,1'b0,1'b1,32'h8000_0010,1'b1,32'h1234_5678,32'h0};
        tbl[2]  = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b0,1'b0,32'h0,        2'd2,1'b0,1'b0,1'b0,1'b1,32'h8000_0010,1'b1,32'h1234_5678,32'h0};
        tbl[3]  = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b1,1'b0,32'h0,        2'd0,1'b1,1'b0,1'b0,1'b1,32'h8000_0010,1'b1,32'h1234_5678,32'h0};
        tbl[4]  = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b0,1'b0,32'h0,        2'd0,1'b0,1'b0,1'b0,1'b1,32'h8000_0010,1'b1,32'h1234_5678,32'h0};
        tbl[5]  = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b1,1'b1,32'hFFFF_FFFF,2'd0,1'b0,1'b0,1'b0,1'b1,32'h8000_0010,1'b1,32'h1234_5678,32'h0};
        tbl[6]  = '{1'b1,1'b1,1'b0,32'h0000_0004,32'hAAAA_5555,2'b00,1'b0,1'b0,32'h0,        2'd1,1'b0,1'b0,1'b0,1'b0,32'h0000_0004,1'b0,32'hAAAA_5555,32'h0};
        tbl[7]  = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b0,1'b0,32'h0,        2'd2,1'b0,1'b0,1'b0,1'b0,32'h0000_0004,1'b0,32'hAAAA_5555,32'h0};
        tbl[8]  = '{1'b1,1'b1,1'b1,32'hFFFF_FFFF,32'h0,        2'b00,1'b0,1'b0,32'h0,        2'd2,1'b0,1'b0,1'b0,1'b0,32'h0000_0004,1'b0,32'hAAAA_5555,32'h0};
        tbl[9]  = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b0,1'b1,32'h1111_1111,2'd2,1'b0,1'b0,1'b0,1'b0,32'h0000_0004,1'b0,32'hAAAA_5555,32'h0};
        tbl[10] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b1,1'b1,32'h2222_2222,2'd3,1'b1,1'b0,1'b0,1'b0,32'h0000_0004,1'b0,32'hAAAA_5555,32'h0};
        tbl[11] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b0,1'b0,32'h0,        2'd3,1'b0,1'b0,1'b0,1'b0,32'h0000_0004,1'b0,32'hAAAA_5555,32'h0};
        tbl[12] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b0,1'b1,32'hDEAD_BEEF,2'd0,1'b0,1'b1,1'b0,1'b0,32'h0000_0004,1'b0,32'hAAAA_5555,32'hDEAD_BEEF};
        tbl[13] = '{1'b1,1'b1,1'b1,32'h8000_0020,32'h5A5A_5A5A,2'b00,1'b0,1'b0,32'h0,        2'd1,1'b0,1'b0,1'b0,1'b1,32'h8000_0020,1'b1,32'h5A5A_5A5A,32'hDEAD_BEEF};
        tbl[14] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b01,1'b0,1'b0,32'h0,        2'd2,1'b0,1'b0,1'b0,1'b1,32'h8000_0020,1'b1,32'h5A5A_5A5A,32'hDEAD_BEEF};
        tbl[15] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        2'b00,1'b1,1'b0,32'h0,        2'd0,1'b1,1'b0,1'b0,1'b1,32'h8000_0020,1'b1,32'h5A5A_5A5A,32'hDEAD_BEEF};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i]);
        end

        // Busy slave 0 for 10 WAIT cycles; slave 1 busy must not matter.
        v = idle(tbl[15]);
        v.req = 1'b1; v.cmd = 1'b0; v.addr = 32'h0000_0100; v.wdata = 32'h0; v.busy = 2'b11;
        v.e_stat = 2'd1; v.e_sfor = 1'b0; v.e_saddr = 32'h0000_0100; v.e_scmd = 1'b0; v.e_swdata = 32'h0;
        step(v);
        v = idle(v); v.busy = 2'b11;
        for (int i = 0; i < 10; i++) step(v);
        v.busy = 2'b10; v.e_stat = 2'd2;
        step(v);
        v = idle(v); v.ack = 1'b1; v.e_stat = 2'd3; v.e_ack = 1'b1;
        step(v);
        v = idle(v);
        step(v);
        v.resp = 1'b1; v.rdata = 32'h0BAD_F00D; v.e_stat = 2'd0; v.e_resp = 1'b1; v.e_rdata = 32'h0BAD_F00D;
        step(v);
        v = idle(v);
        step(v);

        // Timeout in W_ACK: err 5 cycles after entry, nothing else pulses.
        v.req = 1'b1; v.cmd = 1'b1; v.addr = 32'h8000_0040; v.wdata = 32'h0000_0077;
        v.e_stat = 2'd1; v.e_sfor = 1'b1; v.e_saddr = 32'h8000_0040; v.e_scmd = 1'b1; v.e_swdata = 32'h0000_0077;
        step(v);
        v = idle(v); v.e_stat = 2'd2;
        step(v);
        for (int i = 0; i < 4; i++) step(v);
        v.e_stat = 2'd0; v.e_err = 1'b1;
        step(v);
        v = idle(v);
        step(v);

        // Ack on the expiry cycle wins; W_DATA then times out on its own fresh count.
        v.req = 1'b1; v.cmd = 1'b0; v.addr = 32'h0000_0008; v.wdata = 32'h0;
        v.e_stat = 2'd1; v.e_sfor = 1'b0; v.e_saddr = 32'h0000_0008; v.e_scmd = 1'b0; v.e_swdata = 32'h0;
        step(v);
        v = idle(v); v.e_stat = 2'd2;
        step(v);
        for (int i = 0; i < 4; i++) step(v);
        v.ack = 1'b1; v.e_stat = 2'd3; v.e_ack = 1'b1;
        step(v);
        v = idle(v);
        for (int i = 0; i < 4; i++) step(v);
        v.e_stat = 2'd0; v.e_err = 1'b1;
        step(v);
        v = idle(v);
        step(v);

        // Reset during W_DATA with resp_in high: silent drop, then a clean write.
        v.req = 1'b1; v.cmd = 1'b0; v.addr = 32'h0000_000C; v.wdata = 32'h0;
        v.e_stat = 2'd1; v.e_saddr = 32'h0000_000C;
        step(v);
        v = idle(v); v.e_stat = 2'd2;
        step(v);
        v.ack = 1'b1; v.e_stat = 2'd3; v.e_ack = 1'b1;
        step(v);
        v = idle(v); v.rst_n = 1'b0; v.resp = 1'b1; v.rdata = 32'hCAFE_F00D;
        v.e_stat = 2'd0; v.e_sfor = 1'b0; v.e_saddr = 32'h0; v.e_scmd = 1'b0; v.e_swdata = 32'h0; v.e_rdata = 32'h0;
        step(v);
        v = idle(v);
        step(v);
        v.req = 1'b1; v.cmd = 1'b1; v.addr = 32'h8000_0004; v.wdata = 32'h0000_0099;
        v.e_stat = 2'd1; v.e_sfor = 1'b1; v.e_saddr = 32'h8000_0004; v.e_scmd = 1'b1; v.e_swdata = 32'h0000_0099;
        step(v);
        v = idle(v); v.e_stat = 2'd2;
        step(v);
        v.ack = 1'b1; v.e_stat = 2'd0; v.e_ack = 1'b1;
        step(v);
        v = idle(v);
        step(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
